// File: rtl/rx_queue_pkg.sv
// rx_queue_pkg: shared types and helpers for the store-and-forward RX queue.
// Holds the write-FSM state encoding and elaboration-time sizing functions.
package rx_queue_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DROP  = 2'd2
  } wr_state_e;

  localparam int DEF_MAX_FRAME_BYTES = 1522;

  function automatic int keep_width(input int data_width);
    return data_width / 8;
  endfunction

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/rx_sdp_ram.sv
// rx_sdp_ram: simple dual-port RAM, one write port, one registered read port.
// Read data is updated only when a read is requested.
module rx_sdp_ram #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]  i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [WIDTH-1:0]  o_rd_data
);

  logic [WIDTH-1:0] r_mem [2**ADDR_W];
  logic [WIDTH-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/rx_queue_sf.sv
// rx_queue_sf: store-and-forward MAC RX queue with AXI4-Stream output.
// Frames are released only after ending good; others are rewound away.
module rx_queue_sf
  import rx_queue_pkg::*;
#(
  parameter int  AXI_DATA_WIDTH  = 64,
  parameter int  DEPTH_LOG2      = 9,
  parameter int  MAX_FRAME_BYTES = DEF_MAX_FRAME_BYTES,
  parameter int  CNT_WIDTH       = 32,
  localparam int KEEP_WIDTH      = keep_width(AXI_DATA_WIDTH)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [AXI_DATA_WIDTH-1:0] mac_data,
  input  logic [KEEP_WIDTH-1:0]     mac_keep,
  input  logic                      mac_valid,
  input  logic                      mac_last,
  input  logic                      mac_good,
  input  logic                      mac_bad,
  output logic [AXI_DATA_WIDTH-1:0] tdata,
  output logic [KEEP_WIDTH-1:0]     tkeep,
  output logic                      tvalid,
  output logic                      tlast,
  input  logic                      tready,
  output logic                      pkt_start,
  input  logic                      clear_counters,
  output logic [CNT_WIDTH-1:0]      good_frames,
  output logic [CNT_WIDTH-1:0]      bad_frames,
  output logic [CNT_WIDTH-1:0]      ovf_frames
);

  localparam int MAX_BEATS = ceil_div(MAX_FRAME_BYTES, KEEP_WIDTH);
  localparam int DEPTH     = 1 << DEPTH_LOG2;
  localparam int PW        = DEPTH_LOG2 + 1;
  localparam int RW        = AXI_DATA_WIDTH + KEEP_WIDTH + 1;
  localparam int BW        = $clog2(MAX_BEATS + 1);

  if (!(AXI_DATA_WIDTH == 64 || AXI_DATA_WIDTH == 128 ||
        AXI_DATA_WIDTH == 256)) begin : g_width_chk
    $error("rx_queue_sf: AXI_DATA_WIDTH must be 64, 128 or 256");
  end

  typedef logic [PW-1:0]        ptr_t;
  typedef logic [CNT_WIDTH-1:0] cnt_t;

  function automatic cnt_t sat_inc(input cnt_t v);
    return (&v) ? v : v + 1'b1;
  endfunction

  wr_state_e     r_state;
  ptr_t          r_wr_ptr;
  ptr_t          r_commit_ptr;
  ptr_t          r_rd_ptr;
  logic [BW-1:0] r_beats;
  logic          r_pkt_start;
  cnt_t          r_good;
  cnt_t          r_bad;
  cnt_t          r_ovf;

  ptr_t          w_used;
  logic          w_room;
  logic          w_fits;
  logic          w_good;
  logic          w_wr_en;
  logic          w_rd_en;
  logic          w_pop;
  logic [1:0]    w_inflight;
  logic [RW-1:0] w_wr_word;
  logic [RW-1:0] w_rd_word;

  logic          r_ram_vld;
  logic          r_tvalid;
  logic [RW-1:0] r_out_word;
  logic          r_sk_vld;
  logic [RW-1:0] r_sk_word;

  // Free space is judged against the pre-edge read pointer.
  assign w_used    = r_wr_ptr - r_rd_ptr;
  assign w_room    = (DEPTH - int'(w_used)) >= MAX_BEATS;
  assign w_fits    = int'(r_beats) < MAX_BEATS;
  assign w_good    = mac_good & ~mac_bad;
  assign w_wr_word = {mac_last, mac_keep, mac_data};

  always_comb begin
    w_wr_en = 1'b0;
    unique case (r_state)
      ST_IDLE:  w_wr_en = mac_valid & w_room;
      ST_WRITE: w_wr_en = mac_valid & w_fits;
      default:  w_wr_en = 1'b0;
    endcase
    if (reset) w_wr_en = 1'b0;
  end

  rx_sdp_ram #(
    .WIDTH  (RW),
    .ADDR_W (DEPTH_LOG2)
  ) u_ram (
    .clk       (clk),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_wr_ptr[DEPTH_LOG2-1:0]),
    .i_wr_data (w_wr_word),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (r_rd_ptr[DEPTH_LOG2-1:0]),
    .o_rd_data (w_rd_word)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_wr_ptr     <= '0;
      r_commit_ptr <= '0;
      r_rd_ptr     <= '0;
      r_beats      <= '0;
      r_pkt_start  <= 1'b0;
      r_good       <= '0;
      r_bad        <= '0;
      r_ovf        <= '0;
    end else begin
      r_pkt_start <= 1'b0;
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case (r_state)
        ST_IDLE: begin
          if (mac_valid) begin
            if (!w_room) begin
              r_ovf <= sat_inc(r_ovf);
              if (!mac_last) r_state <= ST_DROP;
            end else if (mac_last) begin
              if (w_good) begin
                r_wr_ptr     <= r_wr_ptr + 1'b1;
                r_commit_ptr <= r_wr_ptr + 1'b1;
                r_good       <= sat_inc(r_good);
                r_pkt_start  <= 1'b1;
              end else begin
                r_bad <= sat_inc(r_bad);
              end
            end else begin
              r_wr_ptr <= r_wr_ptr + 1'b1;
              r_beats  <= BW'(1);
              r_state  <= ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          if (mac_valid) begin
            if (!w_fits) begin
              r_wr_ptr <= r_commit_ptr;
              r_bad    <= sat_inc(r_bad);
              r_state  <= mac_last ? ST_IDLE : ST_DROP;
            end else if (mac_last) begin
              if (w_good) begin
                r_wr_ptr     <= r_wr_ptr + 1'b1;
                r_commit_ptr <= r_wr_ptr + 1'b1;
                r_good       <= sat_inc(r_good);
                r_pkt_start  <= 1'b1;
              end else begin
                r_wr_ptr <= r_commit_ptr;
                r_bad    <= sat_inc(r_bad);
              end
              r_state <= ST_IDLE;
            end else begin
              r_wr_ptr <= r_wr_ptr + 1'b1;
              r_beats  <= r_beats + 1'b1;
            end
          end
        end
        ST_DROP: begin
          if (mac_valid & mac_last) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
      if (clear_counters) begin
        r_good <= '0;
        r_bad  <= '0;
        r_ovf  <= '0;
      end
    end
  end

  // Keep at most two words owned by the output/skid pair, counting
  // the one still in the RAM read register.
  assign w_pop      = r_tvalid & tready;
  assign w_inflight = 2'(r_ram_vld) + 2'(r_tvalid) + 2'(r_sk_vld);
  assign w_rd_en    = (r_rd_ptr != r_commit_ptr) &
                      ((w_inflight < 2'd2) |
                       ((w_inflight == 2'd2) & w_pop));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ram_vld  <= 1'b0;
      r_tvalid   <= 1'b0;
      r_out_word <= '0;
      r_sk_vld   <= 1'b0;
      r_sk_word  <= '0;
    end else begin
      r_ram_vld <= w_rd_en;
      if (!r_tvalid || tready) begin
        if (r_sk_vld) begin
          r_out_word <= r_sk_word;
          r_tvalid   <= 1'b1;
          r_sk_vld   <= r_ram_vld;
          if (r_ram_vld) r_sk_word <= w_rd_word;
        end else if (r_ram_vld) begin
          r_out_word <= w_rd_word;
          r_tvalid   <= 1'b1;
        end else begin
          r_tvalid <= 1'b0;
        end
      end else if (r_ram_vld) begin
        r_sk_word <= w_rd_word;
        r_sk_vld  <= 1'b1;
      end
    end
  end

  assign tvalid      = r_tvalid;
  assign tlast       = r_out_word[RW-1];
  assign tkeep       = r_out_word[RW-2 -: KEEP_WIDTH];
  assign tdata       = r_out_word[AXI_DATA_WIDTH-1:0];
  assign pkt_start   = r_pkt_start;
  assign good_frames = r_good;
  assign bad_frames  = r_bad;
  assign ovf_frames  = r_ovf;

endmodule
